data_memory_bank: RTL
=====================

// Module: data_memory_bank
// PURPOSE
//  Parametrised data memory for the MIPS datapath, replacing the fixed 256x32 word RAM.
//  Adds byte/halfword/word stores with byte enables, and sign- or zero-extended sub-word loads.
//  Adds an optional registered read port and a hardware clear sequencer run after reset.
//  Sits in the MEM stage between the ALU result (addr) and the writeback mux (RD).
// PARAMETERS
//  DEPTH     256  number of 32-bit words; power of two, >= 4
//  READ_REG  0    0: combinational read (single-cycle core); 1: RD registered, 1-cycle latency
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-high reset
//  addr         in   32  byte address
//  WD           in   32  store data; the sub-word value is right-justified in WD
//  memWrite     in   1   store request, sampled at posedge clk
//  memRead      in   1   load request
//  size         in   2   dmem_pkg::size_t: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2 (3 is treated as WORD)
//  ld_unsigned  in   1   1: zero-extend sub-word load; 0: sign-extend
//  RD           out  32  load data, extended to 32 bits
//  rd_valid     out  1   RD holds the result of an accepted load
//  busy         out  1   clear sequence in progress; all requests are ignored
//  misalign     out  1   misaligned access flag; tied 0 unless DMEM_ALIGN_CHECK_EN is defined
// BEHAVIOUR
//  - Word index = addr[2 +: $clog2(DEPTH)]. Address bits above the index are ignored, so addresses alias modulo 4*DEPTH.
//  - Byte lanes are little-endian: addr[1:0]=0 selects WD/RAM bits [7:0].
//  - Reset values: state=CLEAR, clr_idx=0, busy=1, RD=0, rd_valid=0, misalign=0.
//  - FSM CLEAR: on each clk, ram[clr_idx]<=0 and clr_idx++. When clr_idx==DEPTH-1 is written, go to READY.
//    busy stays 1 for exactly DEPTH cycles after reset is released.
//  - FSM READY: never leaves READY except on reset.
//    Reset asserted mid-clear (or at any time) restarts CLEAR at clr_idx=0.
//  - While busy: memWrite and memRead are ignored, RD=0, rd_valid=0.
//  - Store (READY & memWrite): at posedge, update only the enabled lanes.
//    BYTE: lane addr[1:0] <= WD[7:0]. HALF: lanes {addr[1],0},+1 <= WD[15:0]. WORD: all lanes <= WD.
//  - Load, READ_REG=0: RD = extended lane(s) of ram[idx], combinational.
//    rd_valid = memRead & ~busy, combinational.
//  - Load, READ_REG=1: at posedge with READY & memRead, RD and rd_valid<=1 are registered.
//    With no load accepted, rd_valid<=0 and RD holds its value.
//  - Load and store to the same word in the same cycle: read-first. RD returns the pre-store data in both modes.
//  - HALF with addr[0]=1 ignores addr[0] when DMEM_ALIGN_CHECK_EN is not defined.
//    WORD likewise ignores addr[1:0].
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined:
//   - misalign = (memRead|memWrite) & ~busy & ((HALF & addr[0]) | (WORD & |addr[1:0])).
//     It is combinational when READ_REG=0 and registered alongside RD when READ_REG=1.
//   - A misaligned store is suppressed (RAM is unchanged).
//   - A misaligned load returns RD=0 with rd_valid still asserted.
//  DMEM_ALIGN_CHECK_EN not defined: misalign is tied 0, and addresses are force-aligned as described above.
// STRUCTURE
//  - dmem_pkg: size_t enum, state_t {CLEAR, READY}, and function lane_mask(size, addr[1:0]) -> 4-bit byte enable.
//  - Sub-module dmem_lane_align is combinational. It does store data replication onto lanes,
//    and load lane extraction plus sign/zero extension.
//  - The top level holds the RAM array, the clear FSM/counter, and the READ_REG generate branch.
// TESTING
//  1. Release reset -> busy=1 for DEPTH (256) cycles then 0; a read of every word returns 0x00000000.
//  2. sw 0x11223344 @0x4, then lw @0x4 -> RD=0x11223344, rd_valid=1 (same cycle for READ_REG=0, next cycle for READ_REG=1).
//  3. sb WD=0x000000AB @0x5 over 0x11223344 -> word 0x1122AB44; lb @0x5 -> 0xFFFFFFAB; lbu @0x5 -> 0x000000AB.
//  4. sh WD=0x8001 @0x6 -> word 0x80013344 (from the case-2 base); lh @0x6 -> 0xFFFF8001; lhu @0x6 -> 0x00008001.
//  5. Macro on: sh @0x3 -> misalign=1 and RAM unchanged; lw @0x2 -> misalign=1 and RD=0.
//     Macro off: misalign stays 0.
//  6. Assert reset at clear cycle 100, release it -> busy for a full 256 cycles. sw/lw during busy are ignored.
//     sw 0xDEADBEEF @0x400 then lw @0x0 -> 0xDEADBEEF (alias).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and byte-enable helper for the MIPS data memory bank.
// Optional misalignment checking is enabled with the DMEM_ALIGN_CHECK_EN macro.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Size code 3 falls through to the word case.
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = 4'b0001 << a;
            SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: replicates store data onto byte lanes and
// extracts/extends the addressed byte or halfword of a loaded word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rword_i,
    output logic [31:0] wlanes_o,
    output logic [31:0] rd_ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Replicated store data lets the byte enables alone pick the lane.
    always_comb begin
        case (size_i)
            SZ_BYTE: wlanes_o = {4{wd_i[7:0]}};
            SZ_HALF: wlanes_o = {2{wd_i[15:0]}};
            default: wlanes_o = wd_i;
        endcase
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rword_i[7:0];
            2'd1:    byte_sel = rword_i[15:8];
            2'd2:    byte_sel = rword_i[23:16];
            default: byte_sel = rword_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    always_comb begin
        case (size_i)
            SZ_BYTE: rd_ext_o = {{24{~ld_unsigned_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: rd_ext_o = {{16{~ld_unsigned_i & half_sel[15]}}, half_sel};
            default: rd_ext_o = rword_i;
        endcase
    end

endmodule

// File: rtl/data_memory_bank.sv
// Parametrised MEM-stage data RAM with sub-word access, post-reset clear
// sequencer and optional registered read. Macro: DMEM_ALIGN_CHECK_EN.
module data_memory_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int READ_REG = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] WD,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    output logic [31:0] RD,
    output logic        rd_valid,
    output logic        busy,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [31:0]   ram [DEPTH];
    state_t        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;

    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wlanes, rd_ext, load_data;
    logic          mis_acc, mis_flag, we, re;

    // Upper address bits alias by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:AW+2];

    assign idx  = addr[2 +: AW];
    assign busy = (state_q == CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LAST_IDX) begin
                state_d   = READY;
                clr_idx_d = '0;
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_acc = ((size == SZ_HALF) & addr[0]) | (size[1] & (|addr[1:0]));
`else
    assign mis_acc = 1'b0;
`endif

    assign mis_flag = (memRead | memWrite) & ~busy & mis_acc;
    assign we       = memWrite & ~busy & ~mis_acc;
    assign re       = memRead & ~busy;
    assign be       = lane_mask(size, addr[1:0]);

    dmem_lane_align u_align (
        .size_i        (size),
        .addr_lo_i     (addr[1:0]),
        .ld_unsigned_i (ld_unsigned),
        .wd_i          (WD),
        .rword_i       (ram[idx]),
        .wlanes_o      (wlanes),
        .rd_ext_o      (rd_ext)
    );

    assign load_data = mis_acc ? 32'h0 : rd_ext;

    // The clear sequencer owns the write port while busy.
    always_ff @(posedge clk) begin
        if (busy) begin
            ram[clr_idx_q] <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ram[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [31:0] rd_q;
            logic        rdv_q, mis_q;

            // Sampled before the store commits, so same-word load+store is read-first.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_q  <= '0;
                    rdv_q <= 1'b0;
                    mis_q <= 1'b0;
                end else begin
                    rdv_q <= re;
                    mis_q <= mis_flag;
                    if (re) rd_q <= load_data;
                end
            end

            assign RD       = rd_q;
            assign rd_valid = rdv_q;
            assign misalign = mis_q;
        end else begin : g_rd_comb
            assign RD       = busy ? 32'h0 : load_data;
            assign rd_valid = re;
            assign misalign = mis_flag;
        end
    endgenerate

endmodule
